// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and framing constants for the serial UART path.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/serial_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sync_fifo
//  Description : Single-clock circular-buffer FIFO with show-ahead read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against misuse so the buffer contents stay coherent regardless of caller.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/serial_tx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_uart
//  Description : Buffered 8N1 UART transmitter with ready/backpressure toward
//                the processor serial write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_uart
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] serial_in,
    input  logic              serial_wren_in,
    output logic              serial_ready_out,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              overflow_err
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(UART_DATA_BITS - 1);

    uart_state_t       r_state;
    uart_state_t       w_next_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic              w_tx_next;
    logic              w_baud_done;
    logic [DATA_W-1:0] w_fifo_rd_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    // Ready depends only on the current occupancy, so a pop never frees a slot
    // for a write on the same edge.
    assign serial_ready_out = !w_fifo_full;
    assign w_push           = serial_wren_in && serial_ready_out;

    serial_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push    (w_push),
        .wr_data (serial_in),
        .pop     (w_pop),
        .rd_data (w_fifo_rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    assign w_baud_done = (r_baud_cnt == c_baud_last);

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done && (r_bit_cnt == c_bit_last)) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tx <= w_tx_next;
            if (serial_wren_in && !serial_ready_out) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_shift    <= w_fifo_rd_data;
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (r_state != IDLE) begin
                if (w_baud_done) begin
                    r_baud_cnt <= '0;
                    if (r_state == DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                end
            end
        end
    end

    assign tx_out       = r_tx;
    assign tx_busy      = (r_state != IDLE) || (w_fifo_count != '0);
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_uart
//  Description : Self-checking bench for serial_tx_uart with a line decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] serial_in = 8'h00;
    logic       serial_wren_in = 1'b0;
    logic       serial_ready_out;
    logic       tx_out;
    logic       tx_busy;
    logic       overflow_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         dec_active = 1'b0;
    int         dec_t = 0;
    logic [7:0] dec_byte = 8'h00;

    serial_tx_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .serial_in        (serial_in),
        .serial_wren_in   (serial_wren_in),
        .serial_ready_out (serial_ready_out),
        .tx_out           (tx_out),
        .tx_busy          (tx_busy),
        .overflow_err     (overflow_err)
    );

    always #5 clock = ~clock;

    // Independent 8N1 receiver: first low sample marks the start bit, bits sampled mid-cell.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (tx_out === 1'b0) begin
                dec_active = 1'b1;
                dec_t      = 0;
                start_q.push_back(cyc);
            end
        end else begin
            dec_t++;
            if (dec_t == CPB / 2) begin
                n_assert++;
                if (tx_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_bit_mid: line=%b required 0", tx_out);
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (dec_t == CPB * (i + 1) + CPB / 2) dec_byte[i] = tx_out;
            end
            if (dec_t == 9 * CPB + CPB / 2) begin
                n_assert++;
                if (tx_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_bit: line=%b required 1", tx_out);
                end
                rx_q.push_back(dec_byte);
            end
            if (dec_t == 10 * CPB - 1) dec_active = 1'b0;
        end
    end

    task automatic wait_drain(input string name);
        int g = 0;
        while (tx_busy !== 1'b0 && g < 3000) begin
            @(negedge clock);
            g++;
        end
        n_assert++;
        if (g >= 3000) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: tx_busy=%b required 0", name, tx_busy);
        end
        repeat (6) @(negedge clock);
    endtask

    // Processor-like writer: only strobes when ready is high.
    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        while (serial_ready_out !== 1'b1 && g < 2000) begin
            @(negedge clock);
            g++;
        end
        if (g >= 2000) begin
            n_assert++;
            n_fail++;
            $display("FAIL ready_timeout: ready=%b required 1", serial_ready_out);
        end
        serial_in      = b;
        serial_wren_in = 1'b1;
        @(negedge clock);
        serial_wren_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_assert += 4;
        if (tx_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx_out); end
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
        if (serial_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", serial_ready_out); end
        if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", overflow_err); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        rx_q.delete();
        serial_in      = 8'hA5;
        serial_wren_in = 1'b1;
        @(negedge clock);
        serial_wren_in = 1'b0;
        @(negedge clock);
        n_assert++;
        if (tx_out !== 1'b1) begin n_fail++; $display("FAIL single_pre_start: line=%b required 1", tx_out); end
        for (int j = 0; j < 10 * CPB; j++) begin
            @(negedge clock);
            n_assert++;
            if (tx_out !== frame[j / CPB]) begin
                n_fail++;
                $display("FAIL single_line cycle %0d: line=%b required %b", j, tx_out, frame[j / CPB]);
            end
        end
        @(negedge clock);
        n_assert += 2;
        if (tx_out !== 1'b1) begin n_fail++; $display("FAIL single_idle: line=%b required 1", tx_out); end
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b required 0", tx_busy); end
        repeat (3) @(negedge clock);
        n_assert++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_rx: frames=%0d byte=%h required 1 frame of a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_burst_recovery();
        logic [7:0] exp_q[$];
        rx_q.delete();
        start_q.delete();
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (serial_ready_out !== (i < 9)) begin
                n_fail++;
                $display("FAIL burst_ready before write %0d: got %b required %b", i, serial_ready_out, (i < 9));
            end
            serial_in      = 8'(i);
            serial_wren_in = 1'b1;
            if (i < 9) exp_q.push_back(8'(i));
            @(negedge clock);
        end
        serial_wren_in = 1'b0;
        n_assert += 2;
        if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL burst_ovf: got %b required 1", overflow_err); end
        if (serial_ready_out !== 1'b0) begin n_fail++; $display("FAIL burst_full: ready=%b required 0", serial_ready_out); end
        // Second pop lands 10*CPB+1 edges after the first; strobe exactly on that edge.
        repeat (10 * CPB + 1 - 9) @(negedge clock);
        n_assert++;
        if (serial_ready_out !== 1'b0) begin n_fail++; $display("FAIL recov_before_pop: ready=%b required 0", serial_ready_out); end
        serial_in      = 8'h55;
        serial_wren_in = 1'b1;
        @(negedge clock);
        n_assert++;
        if (serial_ready_out !== 1'b1) begin n_fail++; $display("FAIL recov_pop_edge_reject: ready=%b required 1", serial_ready_out); end
        @(negedge clock);
        serial_wren_in = 1'b0;
        exp_q.push_back(8'h55);
        n_assert++;
        if (serial_ready_out !== 1'b0) begin n_fail++; $display("FAIL recov_accept: ready=%b required 0", serial_ready_out); end
        wait_drain("burst");
        n_assert++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL burst_count: frames=%0d required %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_assert++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_byte %0d: got %h required %h", i, rx_q[i], exp_q[i]); end
        end
        for (int i = 1; i < start_q.size(); i++) begin
            n_assert++;
            if (start_q[i] - start_q[i-1] != 10 * CPB + 1) begin
                n_fail++;
                $display("FAIL burst_gap %0d: got %0d cycles required %0d", i, start_q[i] - start_q[i-1], 10 * CPB + 1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int lows = 0;
        logic [7:0] bytes [3];
        bytes = '{8'h3C, 8'h11, 8'h22};
        for (int i = 0; i < 3; i++) begin
            serial_in      = bytes[i];
            serial_wren_in = 1'b1;
            @(negedge clock);
        end
        serial_wren_in = 1'b0;
        // DATA bit 3 of the first byte occupies edges k+18..k+21.
        repeat (15) @(negedge clock);
        n_assert += 2;
        if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b required 1", tx_busy); end
        if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL midreset_ovf_before: got %b required 1", overflow_err); end
        reset = 1'b1;
        @(negedge clock);
        n_assert += 4;
        if (tx_out !== 1'b1) begin n_fail++; $display("FAIL midreset_tx: got %b required 1", tx_out); end
        if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", tx_busy); end
        if (serial_ready_out !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b required 1", serial_ready_out); end
        if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf: got %b required 0", overflow_err); end
        @(negedge clock);
        reset = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx_out !== 1'b1) lows++;
        end
        n_assert += 2;
        if (lows != 0) begin n_fail++; $display("FAIL midreset_quiet: low cycles=%0d required 0", lows); end
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL midreset_frames: got %0d required 0", rx_q.size()); end
    endtask

    task automatic test_fibonacci();
        logic [7:0] exp_q[$];
        int a = 1;
        int b = 1;
        int t;
        rx_q.delete();
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(8'(a));
            send_byte(8'(a));
            t = a + b;
            a = b;
            b = t;
        end
        wait_drain("fib");
        n_assert += 2;
        if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fib_ovf: got %b required 0", overflow_err); end
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fib_count: frames=%0d required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_assert++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fib_byte %0d: got %h required %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_wraparound();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        rx_q.delete();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_drain("wrap");
        n_assert += 2;
        if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b required 0", overflow_err); end
        if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count: frames=%0d required %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_assert++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte %0d: got %h required %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_single_byte();
        test_burst_recovery();
        test_reset_midframe();
        test_fibonacci();
        test_wraparound();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
